// File: rtl/btb_upd_arb_pkg.sv
// btb_upd_arb_pkg: shared branch types, arbiter states and BTB update config defaults.
package btb_upd_arb_pkg;
  localparam int AddrWidth = 32;
  localparam int UpdQDepth = 4;
  localparam int UpdStarve = 8;
  typedef enum logic [2:0] {
    BRTYPE_NONE,
    BRTYPE_BRANCH,
    BRTYPE_JUMP,
    BRTYPE_CALL,
    BRTYPE_RET,
    BRTYPE_CALLRET
  } BrInstType_t;
  typedef enum logic [1:0] {ARB_IDLE, ARB_PEND, ARB_FORCE} arb_state_t;
  // A branch commit wins over a simultaneous jump commit.
  function automatic BrInstType_t commit_type(logic br_, logic call_, logic ret_);
    return !br_ ? BRTYPE_BRANCH :
           (!call_ && !ret_) ? BRTYPE_CALLRET :
           !call_ ? BRTYPE_CALL :
           !ret_ ? BRTYPE_RET : BRTYPE_JUMP;
  endfunction
endpackage

// File: rtl/btb_upd_fifo.sv
// btb_upd_fifo: single-write single-read update queue with occupancy count.
module btb_upd_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + PW'(push);
      rp    <= rp + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  assign head = mem[rp];
endmodule

// File: rtl/btb_upd_arb.sv
// btb_upd_arb: shares the single BTB port between fetch lookups and queued commit updates,
// forcing an update through when the queue fills or an entry has starved.
module btb_upd_arb
  import btb_upd_arb_pkg::*;
#(
  parameter int ADDR = AddrWidth,
  parameter int QDEPTH = UpdQDepth,
  parameter int STARVE = UpdStarve
) (
  input  logic                      clk,
  input  logic                      reset_,
  input  logic                      com_br_commit_,
  input  logic                      com_jump_commit_,
  input  logic                      com_call_,
  input  logic                      com_return_,
  input  logic [ADDR-1:0]           com_pc,
  input  logic [ADDR-1:0]           com_tar_addr,
  input  logic                      fetch_req_,
  input  logic [ADDR-1:0]           fetch_pc,
  output logic                      btb_re_,
  output logic                      btb_we_,
  output logic [ADDR-1:0]           btb_addr,
  output logic [ADDR-1:0]           btb_wtar,
  output BrInstType_t               btb_wtype,
  output logic                      fetch_stall_,
  output logic [$clog2(QDEPTH):0]   upd_cnt
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int SW = $clog2(STARVE);
  localparam int TW = $bits(BrInstType_t);
  localparam int DW = 2 * ADDR + TW;
  arb_state_t state, state_next;
  logic [SW-1:0] starve;
  logic push, upd_gnt, fetch_gnt, starve_hit;
  logic [CW-1:0] cnt_next;
  logic [DW-1:0] head;
  btb_upd_fifo #(.DW(DW), .DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .reset_(reset_),
    .push  (push),
    .pop   (upd_gnt),
    .din   ({com_pc, com_tar_addr, commit_type(com_br_commit_, com_call_, com_return_)}),
    .head  (head),
    .count (upd_cnt)
  );
  assign push       = !com_br_commit_ || !com_jump_commit_;
  assign upd_gnt    = (upd_cnt != '0) && (fetch_req_ || state == ARB_FORCE);
  // Reset also blocks the combinational fetch grant so the port is quiet while held.
  assign fetch_gnt  = reset_ && !fetch_req_ && !upd_gnt;
  assign cnt_next   = upd_cnt + CW'(push) - CW'(upd_gnt);
  assign starve_hit = !upd_gnt && starve == SW'(STARVE - 1);
  // Staying in FORCE while the queue would remain full keeps a pending enqueue from overflowing.
  assign state_next = cnt_next == '0 ? ARB_IDLE :
                      (cnt_next == CW'(QDEPTH) || starve_hit) ? ARB_FORCE : ARB_PEND;
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      state  <= ARB_IDLE;
      starve <= '0;
    end else begin
      state  <= state_next;
      starve <= (upd_gnt || upd_cnt == '0) ? '0 :
                (starve == SW'(STARVE - 1)) ? starve : starve + SW'(1);
    end
  assign btb_we_      = !upd_gnt;
  assign btb_re_      = !fetch_gnt;
  assign btb_addr     = upd_gnt ? head[DW-1 -: ADDR] : fetch_gnt ? fetch_pc : '0;
  assign btb_wtar     = upd_gnt ? head[TW +: ADDR] : '0;
  assign btb_wtype    = upd_gnt ? BrInstType_t'(head[TW-1:0]) : BRTYPE_NONE;
  assign fetch_stall_ = !(upd_gnt && !fetch_req_);
endmodule

// File: tb/tb_btb_upd_arb.sv
// tb_btb_upd_arb: directed vector table plus multi-cycle sequences for btb_upd_arb.
module tb_btb_upd_arb;
  import btb_upd_arb_pkg::*;
  localparam int A = 32;
  localparam int QD = 4;
  localparam int ST = 8;
  logic clk = 1'b0;
  logic reset_ = 1'b0;
  logic br_ = 1'b1, jmp_ = 1'b1, call_ = 1'b1, ret_ = 1'b1, freq_ = 1'b1;
  logic [A-1:0] pc = '0, tar = '0, fpc = '0;
  logic re_, we_, stall_;
  logic [A-1:0] addr, wtar;
  BrInstType_t wtype;
  logic [2:0] cnt;
  int checks = 0;
  int errors = 0;

  btb_upd_arb #(.ADDR(A), .QDEPTH(QD), .STARVE(ST)) dut (
    .clk             (clk),
    .reset_          (reset_),
    .com_br_commit_  (br_),
    .com_jump_commit_(jmp_),
    .com_call_       (call_),
    .com_return_     (ret_),
    .com_pc          (pc),
    .com_tar_addr    (tar),
    .fetch_req_      (freq_),
    .fetch_pc        (fpc),
    .btb_re_         (re_),
    .btb_we_         (we_),
    .btb_addr        (addr),
    .btb_wtar        (wtar),
    .btb_wtype       (wtype),
    .fetch_stall_    (stall_),
    .upd_cnt         (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   cmt;
    logic         freq;
    logic [A-1:0] pc, tar, fpc;
    logic [2:0]   ctl;
    logic [A-1:0] addr, wtar;
    BrInstType_t  wtype;
    logic [2:0]   cnt;
  } vec_t;
  vec_t v[15];

  function automatic vec_t mk(logic [3:0] cmt, logic freq, logic [A-1:0] p, t, f,
                              logic [2:0] ctl, logic [A-1:0] a, w, BrInstType_t ty, logic [2:0] c);
    vec_t r;
    r.cmt = cmt; r.freq = freq; r.pc = p; r.tar = t; r.fpc = f;
    r.ctl = ctl; r.addr = a; r.wtar = w; r.wtype = ty; r.cnt = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [72:0] outs();
    return {we_, re_, stall_, addr, wtar, wtype, cnt};
  endfunction

  task automatic quiet();
    {br_, jmp_, call_, ret_} = 4'b1111;
    pc = '0; tar = '0;
  endtask

  initial begin
    int first, nw, maxc, firstw, bad;
    logic [A-1:0] stall_addr;
    logic stall_at;
    BrInstType_t type_at;
    logic [2*A-1:0] got[8];

    // {we_, re_, fetch_stall_} per vector; commit nibble is {br_, jmp_, call_, ret_}
    v[0]  = mk(4'b1111, 1'b1, 32'h0,  32'h0,  32'h0,   3'b111, 32'h0,   32'h0,  BRTYPE_NONE,    3'd0);
    v[1]  = mk(4'b1111, 1'b0, 32'h0,  32'h0,  32'h100, 3'b101, 32'h100, 32'h0,  BRTYPE_NONE,    3'd0);
    v[2]  = mk(4'b0111, 1'b1, 32'h10, 32'h20, 32'h0,   3'b111, 32'h0,   32'h0,  BRTYPE_NONE,    3'd0);
    v[3]  = mk(4'b1111, 1'b1, 32'h0,  32'h0,  32'h0,   3'b011, 32'h10,  32'h20, BRTYPE_BRANCH,  3'd1);
    v[4]  = mk(4'b1111, 1'b1, 32'h0,  32'h0,  32'h0,   3'b111, 32'h0,   32'h0,  BRTYPE_NONE,    3'd0);
    v[5]  = mk(4'b1000, 1'b1, 32'h30, 32'h40, 32'h0,   3'b111, 32'h0,   32'h0,  BRTYPE_NONE,    3'd0);
    v[6]  = mk(4'b0001, 1'b1, 32'h50, 32'h60, 32'h0,   3'b011, 32'h30,  32'h40, BRTYPE_CALLRET, 3'd1);
    v[7]  = mk(4'b1001, 1'b1, 32'h70, 32'h80, 32'h0,   3'b011, 32'h50,  32'h60, BRTYPE_BRANCH,  3'd1);
    v[8]  = mk(4'b1010, 1'b1, 32'h90, 32'ha0, 32'h0,   3'b011, 32'h70,  32'h80, BRTYPE_CALL,    3'd1);
    v[9]  = mk(4'b1011, 1'b1, 32'hb0, 32'hc0, 32'h0,   3'b011, 32'h90,  32'ha0, BRTYPE_RET,     3'd1);
    v[10] = mk(4'b1111, 1'b1, 32'h0,  32'h0,  32'h0,   3'b011, 32'hb0,  32'hc0, BRTYPE_JUMP,    3'd1);
    v[11] = mk(4'b1111, 1'b0, 32'h0,  32'h0,  32'h200, 3'b101, 32'h200, 32'h0,  BRTYPE_NONE,    3'd0);
    v[12] = mk(4'b0111, 1'b0, 32'hd0, 32'he0, 32'h300, 3'b101, 32'h300, 32'h0,  BRTYPE_NONE,    3'd0);
    v[13] = mk(4'b1111, 1'b1, 32'h0,  32'h0,  32'h0,   3'b011, 32'hd0,  32'he0, BRTYPE_BRANCH,  3'd1);
    v[14] = mk(4'b1111, 1'b1, 32'h0,  32'h0,  32'h0,   3'b111, 32'h0,   32'h0,  BRTYPE_NONE,    3'd0);

    freq_ = 1'b0;
    fpc = 32'h55;
    @(negedge clk);
    chk("reset_state", outs(), {3'b111, 32'h0, 32'h0, BRTYPE_NONE, 3'd0});
    tick();
    reset_ = 1'b1;

    for (int i = 0; i < 15; i++) begin
      {br_, jmp_, call_, ret_} = v[i].cmt;
      freq_ = v[i].freq; pc = v[i].pc; tar = v[i].tar; fpc = v[i].fpc;
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(), {v[i].ctl, v[i].addr, v[i].wtar, v[i].wtype, v[i].cnt});
      tick();
    end

    // Fetch hogs the port: a lone jump waits out the starve window, then steals one cycle.
    freq_ = 1'b0; fpc = 32'h400;
    {br_, jmp_, call_, ret_} = 4'b1011; pc = 32'he0; tar = 32'hf0;
    tick();
    quiet();
    first = 0; bad = 0; stall_at = 1'b1; stall_addr = '0; type_at = BRTYPE_NONE;
    for (int i = 1; i <= 20 && first == 0; i++) begin
      @(negedge clk);
      if (!we_) begin
        first = i; stall_at = stall_; stall_addr = addr; type_at = wtype;
      end else if (!stall_) bad++;
      tick();
    end
    chk("starve_latency", first, ST + 1);
    chk("starve_stall", stall_at, 1'b0);
    chk("starve_write", {stall_addr, type_at}, {32'he0, BRTYPE_JUMP});
    chk("starve_early_stall", bad, 0);
    @(negedge clk);
    chk("starve_after", {re_, stall_, cnt}, {1'b0, 1'b1, 3'd0});
    tick();

    // Five back-to-back branch commits with fetch held: queue fills, nothing is lost.
    nw = 0; maxc = 0; firstw = -1;
    for (int c = 0; c < 120; c++) begin
      if (c < 5) begin
        br_ = 1'b0; pc = 32'h1000 + 32'(c * 16); tar = 32'h2000 + 32'(c);
      end else quiet();
      @(negedge clk);
      if (int'(cnt) > maxc) maxc = int'(cnt);
      if (!we_) begin
        if (firstw < 0) firstw = c;
        if (nw < 8) got[nw] = {addr, wtar};
        nw++;
      end
      tick();
    end
    chk("full_first_write", firstw, 4);
    chk("full_max_cnt", maxc, QD);
    chk("full_write_count", nw, 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("full_order%0d", k), got[k], {32'h1000 + 32'(k * 16), 32'h2000 + 32'(k)});
    @(negedge clk);
    chk("full_drained", cnt, 3'd0);
    tick();

    // Asynchronous reset with three entries queued drops them all.
    for (int c = 0; c < 3; c++) begin
      br_ = 1'b0; pc = 32'h5000 + 32'(c); tar = 32'h6000;
      tick();
    end
    quiet();
    @(negedge clk);
    chk("pre_reset_cnt", cnt, 3'd3);
    #2;
    reset_ = 1'b0;
    #1;
    chk("async_reset", outs(), {3'b111, 32'h0, 32'h0, BRTYPE_NONE, 3'd0});
    tick();
    reset_ = 1'b1;
    freq_ = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!we_) bad++;
      tick();
    end
    chk("no_write_after_reset", bad, 0);

    // First commit after reset behaves as from an empty queue.
    br_ = 1'b0; pc = 32'h7000; tar = 32'h7100;
    @(negedge clk);
    chk("post_reset_nobypass", {we_, cnt}, {1'b1, 3'd0});
    tick();
    quiet();
    @(negedge clk);
    chk("post_reset_write", outs(), {3'b011, 32'h7000, 32'h7100, BRTYPE_BRANCH, 3'd1});
    tick();
    @(negedge clk);
    chk("post_reset_drain", {we_, cnt}, {1'b1, 3'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
